// File: rtl/npu_pkg.sv
// Shared NPU definitions: weight width and the weight-load controller state encoding.
package npu_pkg;

  localparam int unsigned WEIGHT_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StReady
  } w_ld_state_t;

endpackage

// File: rtl/w_load_ctrl_if.sv
// Handshake, SRAM read and circular-register signals of the weight-load controller.
interface w_load_ctrl_if
  import npu_pkg::*;
#(
  parameter int unsigned K_H    = 3,
  parameter int unsigned K_W    = 3,
  parameter int unsigned ADDR_W = 10
);

  localparam int unsigned ColW = (K_W > 1) ? $clog2(K_W) : 1;

  logic                             start;
  logic [ADDR_W-1:0]                base_addr;
  logic                             start_ready;
  logic                             release_req;
  logic                             step;
  logic                             mem_rd_en;
  logic [ADDR_W-1:0]                mem_addr;
  logic [K_H*WEIGHT_W-1:0]          mem_rd_data;
  logic                             clear;
  logic                             load_en;
  logic [K_H-1:0][WEIGHT_W-1:0]     in_data;
  logic                             shift;
  logic                             w_valid;
  logic [ColW-1:0]                  col_idx;

  modport slave (
    input  start, base_addr, release_req, step, mem_rd_data,
    output start_ready, mem_rd_en, mem_addr, clear, load_en, in_data, shift, w_valid, col_idx
  );

  modport master (
    output start, base_addr, release_req, step, mem_rd_data,
    input  start_ready, mem_rd_en, mem_addr, clear, load_en, in_data, shift, w_valid, col_idx
  );

endinterface

// File: rtl/w_load_ctrl.sv
// Weight-load controller: fetches one K_H x K_W kernel column-by-column into the PE circular
// weight register, then turns step requests into single-cycle shift pulses.
module w_load_ctrl
  import npu_pkg::*;
#(
  parameter int unsigned K_H    = 3,
  parameter int unsigned K_W    = 3,
  parameter int unsigned ADDR_W = 10
) (
  input logic         clk,
  input logic         rst,
  w_load_ctrl_if.slave bus
);

  localparam int unsigned ColW = (K_W > 1) ? $clog2(K_W) : 1;
  localparam logic [ColW-1:0] LastCol = ColW'(K_W - 1);

  w_ld_state_t       state_q, state_d;
  logic [ColW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [ColW-1:0]   col_idx_q, col_idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              load_en_q;
  logic              shift_q, shift_d;
  logic              fetching;

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    col_idx_d = col_idx_q;
    base_d    = base_q;
    shift_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StFetch;
          rd_cnt_d  = '0;
          col_idx_d = '0;
          base_d    = bus.base_addr;
        end
      end
      StFetch: begin
        if (rd_cnt_q == LastCol) begin
          state_d  = StDrain;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + ColW'(1);
        end
      end
      StDrain: state_d = StReady;
      StReady: begin
        // Reload wins over release; a step alongside either is dropped.
        if (bus.start) begin
          state_d   = StFetch;
          rd_cnt_d  = '0;
          col_idx_d = '0;
          base_d    = bus.base_addr;
        end else if (bus.release_req) begin
          state_d = StIdle;
        end else if (bus.step) begin
          shift_d   = 1'b1;
          col_idx_d = (col_idx_q == LastCol) ? '0 : col_idx_q + ColW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rd_cnt_q  <= '0;
      col_idx_q <= '0;
      base_q    <= '0;
      load_en_q <= 1'b0;
      shift_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      col_idx_q <= col_idx_d;
      base_q    <= base_d;
      // SRAM data lands one cycle after the read strobe.
      load_en_q <= fetching;
      shift_q   <= shift_d;
    end
  end

  assign fetching        = (state_q == StFetch);
  assign bus.mem_rd_en   = fetching;
  assign bus.mem_addr    = fetching ? base_q + ADDR_W'(rd_cnt_q) : '0;
  assign bus.clear       = fetching && (rd_cnt_q == '0);
  assign bus.load_en     = load_en_q;
  assign bus.shift       = shift_q;
  assign bus.w_valid     = (state_q == StReady);
  assign bus.start_ready = (state_q == StIdle) || (state_q == StReady);
  assign bus.col_idx     = col_idx_q;

  always_comb begin
    for (int i = 0; i < int'(K_H); i++) begin
      bus.in_data[i] = bus.mem_rd_data[WEIGHT_W*i +: WEIGHT_W];
    end
  end

endmodule

// File: tb/tb_w_load_ctrl.sv
// Randomized and directed bench for w_load_ctrl against a timestamp-based reference model.
module tb_w_load_ctrl;

  localparam int K_H    = 3;
  localparam int K_W    = 3;
  localparam int ADDR_W = 10;
  localparam int N      = 2048;

  logic clk;
  logic rst;

  w_load_ctrl_if #(.K_H(K_H), .K_W(K_W), .ADDR_W(ADDR_W)) bus ();

  w_load_ctrl #(.K_H(K_H), .K_W(K_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [K_H*8-1:0] mem [1024];

  // SRAM responder: one-cycle read latency, zero when not read.
  always @(posedge clk) begin
    bus.mem_rd_data <= bus.mem_rd_en ? mem[bus.mem_addr] : '0;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Expected per-cycle events, indexed by cycle number.
  bit               e_rd    [N];
  bit               e_clear [N];
  bit               e_load  [N];
  bit               e_shift [N];
  logic [ADDR_W-1:0] e_addr [N];
  logic [K_H*8-1:0] e_data  [N];

  int cnum     = 0;
  bit known    = 0;
  bit have     = 0;
  int ready_at = 0;
  int col_now  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cnum, obs, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic [ADDR_W-1:0] ba, input logic rl,
                     input logic sp, input logic r);
    bit in_ready;
    bit loading;
    @(negedge clk);
    bus.start       = st;
    bus.base_addr   = ba;
    bus.release_req = rl;
    bus.step        = sp;
    rst             = r;
    #1;
    in_ready = have && (cnum >= ready_at);
    loading  = have && (cnum < ready_at);
    if (known) begin
      chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(e_rd[cnum]));
      if (e_rd[cnum]) chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr[cnum]));
      chk("clear", 32'(bus.clear), 32'(e_clear[cnum]));
      chk("load_en", 32'(bus.load_en), 32'(e_load[cnum]));
      if (e_load[cnum]) chk("in_data", 32'(bus.in_data), 32'(e_data[cnum]));
      chk("shift", 32'(bus.shift), 32'(e_shift[cnum]));
      chk("w_valid", 32'(bus.w_valid), 32'(in_ready));
      chk("start_ready", 32'(bus.start_ready), 32'(!loading));
      if (in_ready) chk("col_idx", 32'(bus.col_idx), 32'(col_now));
    end
    if (r) begin
      have    = 0;
      col_now = 0;
      known   = 1;
      for (int i = cnum + 1; i <= cnum + K_W + 3; i++) begin
        e_rd[i] = 0; e_clear[i] = 0; e_load[i] = 0; e_shift[i] = 0;
      end
    end else if (st && !loading) begin
      have     = 1;
      ready_at = cnum + K_W + 2;
      col_now  = 0;
      e_clear[cnum+1] = 1;
      for (int j = 0; j < K_W; j++) begin
        e_rd[cnum+1+j]   = 1;
        e_addr[cnum+1+j] = ADDR_W'((int'(ba) + j) % (1 << ADDR_W));
        e_load[cnum+2+j] = 1;
        e_data[cnum+2+j] = mem[(int'(ba) + j) % (1 << ADDR_W)];
      end
    end else if (rl && in_ready) begin
      have = 0;
    end else if (sp && in_ready) begin
      e_shift[cnum+1] = 1;
      col_now = (col_now + 1) % K_W;
    end
    cnum++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = (K_H*8)'($urandom);
    for (int i = 0; i < N; i++) begin
      e_rd[i] = 0; e_clear[i] = 0; e_load[i] = 0; e_shift[i] = 0;
      e_addr[i] = '0; e_data[i] = '0;
    end
    bus.start = 0; bus.base_addr = '0; bus.release_req = 0; bus.step = 0; rst = 1;

    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Basic load at 0x010 and a run of four steps.
    cyc(1'b1, 10'h010, 1'b0, 1'b0, 1'b0);
    idle(6);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Steps during fetch are dropped; step with release is dropped.
    cyc(1'b1, 10'h100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(1);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Start during fetch is ignored.
    cyc(1'b1, 10'h020, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 10'h200, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 10'h200, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Reload from READY with address wrap; start beats release.
    cyc(1'b1, 10'h3FE, 1'b1, 1'b1, 1'b0);
    idle(6);

    // Reset in the middle of a load, then a clean load.
    cyc(1'b1, 10'h040, 1'b0, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(2);
    cyc(1'b1, 10'h050, 1'b0, 1'b0, 1'b0);
    idle(6);

    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 7) == 0), ADDR_W'($urandom_range(0, 1023)),
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 199) == 0));
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
